// File: rtl/branch_update_unit.sv
// Branch resolution and predictor-table update unit: flags mispredicts from EX results
// and read-modify-writes the pattern-history and info/target tables, one update per cycle.
module branch_update_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int HASH_DEPTH = 5,
    parameter int PARA_WIDTH = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ex_in_vld,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_br,
    input  logic                  ex_cond,
    input  logic                  ex_taken,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] ex_pred_target,
    output logic [HASH_DEPTH-1:0] past_raddr,
    input  logic [PARA_WIDTH-1:0] past_rdata1,
    input  logic [PARA_WIDTH-1:0] past_rdata2,
    input  logic                  past_rvld1,
    input  logic                  past_rvld2,
    output logic                  past_we,
    output logic [HASH_DEPTH-1:0] past_waddr,
    output logic                  past_wslot,
    output logic [PARA_WIDTH-1:0] past_wdata,
    output logic                  info_we,
    output logic [HASH_DEPTH-1:0] info_waddr,
    output logic                  info_wslot,
    output logic [ADDR_WIDTH-1:0] info_wdata,
    output logic                  ex_vld,
    output logic                  ex_wrong,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  br_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    // Entry used when the table slot is not valid yet: h=00, every counter weakly not-taken.
    localparam logic [PARA_WIDTH-1:0] COLD_ENTRY = PARA_WIDTH'(10'b00_01_01_01_01);

    logic                  acc;
    logic                  wrong_a;
    logic [HASH_DEPTH-1:0] a_idx;

    logic [HASH_DEPTH-1:0] b_idx;
    logic                  b_slot;
    logic                  b_cond;
    logic                  b_taken;
    logic [ADDR_WIDTH-3:0] b_tgt;

    logic                  fwd_vld;
    logic [PARA_WIDTH-1:0] fwd_data;

    logic [PARA_WIDTH-1:0] sel_d;
    logic                  sel_v;
    logic [PARA_WIDTH-1:0] cur_e;
    logic [PARA_WIDTH-1:0] new_e;
    logic [1:0]            h;
    logic [1:0]            cur_c;
    logic [1:0]            nxt_c;

    // Inputs arriving while a mispredict is being reported are wrong-path and dropped.
    assign acc        = ex_in_vld & ex_br & ~ex_wrong;
    assign wrong_a    = (ex_pred_taken != ex_taken) | (ex_taken & (ex_pred_target != ex_target));
    assign a_idx      = ex_pc[HASH_DEPTH+2:3];
    assign past_raddr = a_idx;

    always_comb begin
        sel_d = b_slot ? past_rdata2 : past_rdata1;
        sel_v = b_slot ? past_rvld2  : past_rvld1;
        if (fwd_vld)
            cur_e = fwd_data;
        else if (sel_v)
            cur_e = sel_d;
        else
            cur_e = COLD_ENTRY;

        h     = cur_e[9:8];
        cur_c = 2'b00;
        for (int k = 0; k < 4; k++)
            if (h == 2'(k)) cur_c = cur_e[2*k +: 2];

        if (b_taken)
            nxt_c = (cur_c == 2'b11) ? cur_c : cur_c + 2'd1;
        else
            nxt_c = (cur_c == 2'b00) ? cur_c : cur_c - 2'd1;

        new_e = cur_e;
        for (int k = 0; k < 4; k++)
            if (h == 2'(k)) new_e[2*k +: 2] = nxt_c;
        new_e[9:8] = {h[0], b_taken};
    end

    assign past_we    = ex_vld & b_cond;
    assign past_waddr = past_we ? b_idx : '0;
    assign past_wslot = past_we & b_slot;
    assign past_wdata = past_we ? new_e : '0;

    // Conditional branches mark the info entry valid (bit0) since the history entry is written too.
    assign info_we    = ex_vld & b_taken;
    assign info_waddr = info_we ? b_idx : '0;
    assign info_wslot = info_we & b_slot;
    assign info_wdata = info_we ? {b_tgt, ~b_cond, b_cond} : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_vld      <= 1'b0;
            ex_wrong    <= 1'b0;
            redirect_pc <= '0;
            b_idx       <= '0;
            b_slot      <= 1'b0;
            b_cond      <= 1'b0;
            b_taken     <= 1'b0;
            b_tgt       <= '0;
            fwd_vld     <= 1'b0;
            fwd_data    <= '0;
            br_cnt      <= '0;
            miss_cnt    <= '0;
        end else begin
            ex_vld   <= acc;
            ex_wrong <= acc & wrong_a;
            if (acc) begin
                b_idx       <= a_idx;
                b_slot      <= ex_pc[2];
                b_cond      <= ex_cond;
                b_taken     <= ex_taken;
                b_tgt       <= ex_target[ADDR_WIDTH-1:2];
                redirect_pc <= ex_taken ? ex_target : ex_pc + ADDR_WIDTH'(4);
            end
            // The table returns stale data when read and written in the same cycle, so carry the write.
            fwd_vld  <= acc & past_we & (a_idx == b_idx) & (ex_pc[2] == b_slot);
            fwd_data <= new_e;
            if (ex_vld && !(&br_cnt))
                br_cnt <= br_cnt + CNT_WIDTH'(1);
            if (ex_wrong && !(&miss_cnt))
                miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_update_unit.sv
// Bench for branch_update_unit: drives EX results, emulates the history table, and checks
// every cycle against a behavioural model of the resolution and update rules.
module tb_branch_update_unit;

    localparam int AW = 32;
    localparam int HD = 5;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ex_in_vld = 1'b0;
    logic [AW-1:0] ex_pc = '0;
    logic          ex_br = 1'b0;
    logic          ex_cond = 1'b0;
    logic          ex_taken = 1'b0;
    logic [AW-1:0] ex_target = '0;
    logic          ex_pred_taken = 1'b0;
    logic [AW-1:0] ex_pred_target = '0;
    logic [PW-1:0] past_rdata1 = '0;
    logic [PW-1:0] past_rdata2 = '0;
    logic          past_rvld1 = 1'b0;
    logic          past_rvld2 = 1'b0;

    logic [HD-1:0] past_raddr, past_waddr, info_waddr;
    logic          past_we, past_wslot, info_we, info_wslot, ex_vld, ex_wrong;
    logic [PW-1:0] past_wdata;
    logic [AW-1:0] info_wdata, redirect_pc;
    logic [31:0]   br_cnt, miss_cnt;

    logic [HD-1:0] past_raddr_2, past_waddr_2, info_waddr_2;
    logic          past_we_2, past_wslot_2, info_we_2, info_wslot_2, ex_vld_2, ex_wrong_2;
    logic [PW-1:0] past_wdata_2;
    logic [AW-1:0] info_wdata_2, redirect_pc_2;
    logic [3:0]    br_cnt_2, miss_cnt_2;

    always #5 clk = ~clk;

    branch_update_unit dut (
        .clk(clk), .rstn(rstn), .ex_in_vld(ex_in_vld), .ex_pc(ex_pc), .ex_br(ex_br),
        .ex_cond(ex_cond), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .past_raddr(past_raddr), .past_rdata1(past_rdata1), .past_rdata2(past_rdata2),
        .past_rvld1(past_rvld1), .past_rvld2(past_rvld2), .past_we(past_we),
        .past_waddr(past_waddr), .past_wslot(past_wslot), .past_wdata(past_wdata),
        .info_we(info_we), .info_waddr(info_waddr), .info_wslot(info_wslot),
        .info_wdata(info_wdata), .ex_vld(ex_vld), .ex_wrong(ex_wrong),
        .redirect_pc(redirect_pc), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    // Narrow-counter instance so counter saturation is reachable in a short run.
    branch_update_unit #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rstn(rstn), .ex_in_vld(ex_in_vld), .ex_pc(ex_pc), .ex_br(ex_br),
        .ex_cond(ex_cond), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .past_raddr(past_raddr_2), .past_rdata1(past_rdata1), .past_rdata2(past_rdata2),
        .past_rvld1(past_rvld1), .past_rvld2(past_rvld2), .past_we(past_we_2),
        .past_waddr(past_waddr_2), .past_wslot(past_wslot_2), .past_wdata(past_wdata_2),
        .info_we(info_we_2), .info_waddr(info_waddr_2), .info_wslot(info_wslot_2),
        .info_wdata(info_wdata_2), .ex_vld(ex_vld_2), .ex_wrong(ex_wrong_2),
        .redirect_pc(redirect_pc_2), .br_cnt(br_cnt_2), .miss_cnt(miss_cnt_2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- history table emulation (old data on same-cycle read/write) ----------------
    logic [PW-1:0] init_d [32][2];
    logic          init_v [32][2];
    logic          load_mem = 1'b1;
    logic [PW-1:0] mem_d [32][2];
    logic          mem_v [32][2];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 32; i++)
                for (int s = 0; s < 2; s++) begin
                    mem_d[i][s] <= init_d[i][s];
                    mem_v[i][s] <= init_v[i][s];
                end
        end else begin
            past_rdata1 <= mem_d[past_raddr][0];
            past_rdata2 <= mem_d[past_raddr][1];
            past_rvld1  <= mem_v[past_raddr][0];
            past_rvld2  <= mem_v[past_raddr][1];
            if (rstn && past_we) begin
                mem_d[past_waddr][past_wslot] <= past_wdata;
                mem_v[past_waddr][past_wslot] <= 1'b1;
            end
        end
    end

    // ---------------- behavioural model ----------------
    function automatic logic [PW-1:0] hist_update(input logic [PW-1:0] e, input logic v, input logic tk);
        int c[4];
        int h;
        if (!v) begin
            h = 0;
            for (int k = 0; k < 4; k++) c[k] = 1;
        end else begin
            h = int'(e[9:8]);
            for (int k = 0; k < 4; k++) c[k] = int'(e[2*k +: 2]);
        end
        if (tk) c[h] = (c[h] < 3) ? c[h] + 1 : 3;
        else    c[h] = (c[h] > 0) ? c[h] - 1 : 0;
        h = (h % 2) * 2 + (tk ? 1 : 0);
        return {2'(h), 2'(c[3]), 2'(c[2]), 2'(c[1]), 2'(c[0])};
    endfunction

    logic [PW-1:0] m_d [32][2];
    logic          m_v [32][2];
    logic          p_vld = 1'b0;
    logic [HD-1:0] p_idx;
    logic          p_slot, p_cond, p_taken, p_wrong;
    logic [AW-1:0] p_target, p_redirect;
    longint        m_br = 0;
    longint        m_miss = 0;

    logic          cap_en = 1'b0;
    logic [31:0]   cap_wrong[$], cap_redir[$], cap_we[$], cap_wd[$], cap_iwe[$], cap_iwd[$];

    always @(negedge clk) begin
        logic e_wrong, e_we, e_iwe;
        logic [PW-1:0] e_wd;
        if (load_mem)
            for (int i = 0; i < 32; i++)
                for (int s = 0; s < 2; s++) begin
                    m_d[i][s] = init_d[i][s];
                    m_v[i][s] = init_v[i][s];
                end
        if (!rstn) begin
            p_vld  = 1'b0;
            m_br   = 0;
            m_miss = 0;
        end else begin
            e_wrong = p_vld & p_wrong;
            e_we    = p_vld & p_cond;
            e_iwe   = p_vld & p_taken;
            chk("ex_vld", 64'(ex_vld), 64'(p_vld));
            chk("ex_wrong", 64'(ex_wrong), 64'(e_wrong));
            chk("past_we", 64'(past_we), 64'(e_we));
            chk("info_we", 64'(info_we), 64'(e_iwe));
            chk("past_raddr", 64'(past_raddr), 64'(ex_pc[HD+2:3]));
            chk("br_cnt", 64'(br_cnt), 64'(m_br));
            chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
            chk("br_cnt_sat4", 64'(br_cnt_2), (m_br > 15) ? 64'd15 : 64'(m_br));
            chk("miss_cnt_sat4", 64'(miss_cnt_2), (m_miss > 15) ? 64'd15 : 64'(m_miss));
            if (e_wrong)
                chk("redirect_pc", 64'(redirect_pc), 64'(p_redirect));
            if (e_we) begin
                e_wd = hist_update(m_d[p_idx][p_slot], m_v[p_idx][p_slot], p_taken);
                m_d[p_idx][p_slot] = e_wd;
                m_v[p_idx][p_slot] = 1'b1;
                chk("past_waddr", 64'(past_waddr), 64'(p_idx));
                chk("past_wslot", 64'(past_wslot), 64'(p_slot));
                chk("past_wdata", 64'(past_wdata), 64'(e_wd));
            end
            if (e_iwe) begin
                chk("info_waddr", 64'(info_waddr), 64'(p_idx));
                chk("info_wslot", 64'(info_wslot), 64'(p_slot));
                chk("info_wdata", 64'(info_wdata), 64'({p_target[AW-1:2], ~p_cond, p_cond}));
            end
            if (cap_en && ex_vld) begin
                cap_wrong.push_back(32'(ex_wrong));
                cap_redir.push_back(redirect_pc);
                cap_we.push_back(32'(past_we));
                cap_wd.push_back(32'(past_wdata));
                cap_iwe.push_back(32'(info_we));
                cap_iwd.push_back(info_wdata);
            end
            if (p_vld) m_br++;
            if (e_wrong) m_miss++;
            if (ex_in_vld && ex_br && !e_wrong) begin
                p_vld      = 1'b1;
                p_idx      = ex_pc[HD+2:3];
                p_slot     = ex_pc[2];
                p_cond     = ex_cond;
                p_taken    = ex_taken;
                p_target   = ex_target;
                p_wrong    = (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target);
                p_redirect = ex_taken ? ex_target : ex_pc + 32'd4;
            end else begin
                p_vld = 1'b0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic v, input logic br, input logic cond, input logic tk,
                         input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                         input logic ptk, input logic [AW-1:0] ptgt);
        @(posedge clk);
        #1;
        ex_in_vld      = v;
        ex_br          = br;
        ex_cond        = cond;
        ex_taken       = tk;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, ex_pc, 32'h0, 1'b0, 32'h0);
    endtask

    logic [31:0] lit_wrong[7], lit_redir[7], lit_we[7], lit_wd[7], lit_iwd[7];
    logic [AW-1:0] pool[6];

    initial begin
        int n;
        logic c, t, pt;
        logic [AW-1:0] pc, tg, ptg;

        for (int i = 0; i < 32; i++)
            for (int s = 0; s < 2; s++) begin
                init_d[i][s] = PW'($urandom);
                init_v[i][s] = 1'($urandom_range(0, 1));
            end
        init_v[2][0] = 1'b0;
        init_v[4][1] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_vld", 64'(ex_vld), 64'd0);
        chk("rst_ex_wrong", 64'(ex_wrong), 64'd0);
        chk("rst_past_we", 64'(past_we), 64'd0);
        chk("rst_info_we", 64'(info_we), 64'd0);
        chk("rst_redirect", 64'(redirect_pc), 64'd0);
        chk("rst_br_cnt", 64'(br_cnt), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        chk("rst_past_wdata", 64'(past_wdata), 64'd0);
        chk("rst_info_wdata", 64'(info_wdata), 64'd0);
        load_mem = 1'b0;
        rstn     = 1'b1;

        // Directed: cold mispredict, back-to-back saturation, jump mispredict, wrong-path drop.
        lit_wrong = '{1, 0, 0, 0, 0, 0, 1};
        lit_redir = '{32'h1C000100, 0, 0, 0, 0, 0, 32'h1C000200};
        lit_we    = '{1, 1, 1, 1, 1, 1, 0};
        lit_wd    = '{32'h156, 32'h156, 32'h35A, 32'h39A, 32'h3DA, 32'h3DA, 0};
        lit_iwd   = '{32'h1C000101, 32'h1C000401, 32'h1C000401, 32'h1C000401,
                      32'h1C000401, 32'h1C000401, 32'h1C000202};
        cap_en = 1'b1;
        drive(1, 1, 1, 1, 32'h1C000010, 32'h1C000100, 0, 32'h0);
        idle();
        repeat (5) drive(1, 1, 1, 1, 32'h1C000024, 32'h1C000400, 1, 32'h1C000400);
        drive(1, 1, 0, 1, 32'h1C000030, 32'h1C000200, 1, 32'h1C000300);
        drive(1, 1, 1, 0, 32'h1C000040, 32'h1C000500, 0, 32'h0);
        idle();
        idle();
        idle();
        cap_en = 1'b0;
        chk("lit_count", 64'(cap_wrong.size()), 64'd7);
        chk("lit_br_cnt", 64'(br_cnt), 64'd7);
        chk("lit_miss_cnt", 64'(miss_cnt), 64'd2);
        n = cap_wrong.size();
        for (int i = 0; i < n && i < 7; i++) begin
            chk($sformatf("lit_wrong%0d", i), 64'(cap_wrong.pop_front()), 64'(lit_wrong[i]));
            if (lit_wrong[i] != 0)
                chk($sformatf("lit_redir%0d", i), 64'(cap_redir[0]), 64'(lit_redir[i]));
            void'(cap_redir.pop_front());
            chk($sformatf("lit_we%0d", i), 64'(cap_we.pop_front()), 64'(lit_we[i]));
            if (lit_we[i] != 0)
                chk($sformatf("lit_wdata%0d", i), 64'(cap_wd[0]), 64'(lit_wd[i]));
            void'(cap_wd.pop_front());
            chk($sformatf("lit_iwe%0d", i), 64'(cap_iwe.pop_front()), 64'd1);
            chk($sformatf("lit_iwdata%0d", i), 64'(cap_iwd.pop_front()), 64'(lit_iwd[i]));
        end

        // Reset while an update is in its write cycle.
        drive(1, 1, 1, 1, 32'h1C000058, 32'h1C000600, 1, 32'h1C000600);
        @(posedge clk);
        #1 ex_in_vld = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("midrst_ex_vld", 64'(ex_vld), 64'd0);
        chk("midrst_past_we", 64'(past_we), 64'd0);
        chk("midrst_info_we", 64'(info_we), 64'd0);
        chk("midrst_redirect", 64'(redirect_pc), 64'd0);
        chk("midrst_br_cnt", 64'(br_cnt), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) idle();

        // Randomized traffic over a small PC pool so same-slot back-to-back updates are common.
        pool = '{32'h1C000010, 32'h1C000014, 32'h1C000024, 32'h1C000058, 32'h1C00007C, 32'h1C0000A0};
        for (int i = 0; i < 600; i++) begin
            pc  = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 5)];
            c   = ($urandom_range(0, 3) != 0);
            t   = c ? 1'($urandom_range(0, 1)) : 1'b1;
            tg  = {$urandom_range(0, 255), 2'b00} + 32'h1C001000;
            pt  = ($urandom_range(0, 4) == 0) ? ~t : t;
            ptg = ($urandom_range(0, 5) == 0) ? tg ^ 32'h40 : tg;
            drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 8) != 0), c, t, pc, tg, pt, ptg);
        end
        repeat (3) idle();
        chk("final_br_cnt_sat4", 64'(br_cnt_2), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_update_unit.md
Name: branch_update_unit

Overview:
- Resolution-side partner of the fetch-stage predictor.
- Accepts resolved branch outcomes from EX and decides whether each was mispredicted.
- Returns ex_vld/ex_wrong plus a redirect PC to the predictor and fetch.
- Read-modify-writes the per-slot 10-bit pattern-history entries and the 32-bit info/target entries that the predictor reads, with one update accepted per cycle.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- HASH_DEPTH, 5, table index width; index = pc[HASH_DEPTH+2:3].
- PARA_WIDTH, 10, history entry width: [9:8] local history h; counters c0=[1:0], c1=[3:2], c2=[5:4], c3=[7:6].
- CNT_WIDTH, 32, performance counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ex_in_vld  in  1  EX presents a resolved instruction
- ex_pc  in  ADDR_WIDTH  its PC
- ex_br  in  1  instruction is a branch/jump
- ex_cond  in  1  branch is conditional (0 = unconditional)
- ex_taken  in  1  actual direction
- ex_target  in  ADDR_WIDTH  actual target
- ex_pred_taken  in  1  direction predicted at fetch
- ex_pred_target  in  ADDR_WIDTH  target predicted at fetch
- past_raddr  out  HASH_DEPTH  history table read index
- past_rdata1, past_rdata2  in  PARA_WIDTH  slot0/slot1 entries, valid one cycle after past_raddr
- past_rvld1, past_rvld2  in  1  entry-valid bits, same timing as past_rdata
- past_we  out  1  history write strobe
- past_waddr  out  HASH_DEPTH  history write index
- past_wslot  out  1  history write slot, equal to pc[2]
- past_wdata  out  PARA_WIDTH  history write data
- info_we  out  1  info write strobe
- info_waddr  out  HASH_DEPTH  info write index
- info_wslot  out  1  info write slot
- info_wdata  out  ADDR_WIDTH  info write data
- ex_vld  out  1  resolution result valid (to predictor)
- ex_wrong  out  1  mispredict (to predictor)
- redirect_pc  out  ADDR_WIDTH  correct next PC, meaningful when ex_wrong=1
- br_cnt  out  CNT_WIDTH  resolved branch count
- miss_cnt  out  CNT_WIDTH  mispredict count

Behaviour:
- Reset: every register and output is 0, counters are 0, no writes issued. Reset asserted mid-update aborts that write; no partial write survives.
- Stage A (cycle t): an update is accepted when acc = ex_in_vld & ex_br & ~ex_wrong.
  - past_raddr = ex_pc[HASH_DEPTH+2:3] is driven combinationally from ex_pc every cycle.
  - acc latches pc, cond, taken, target.
  - Wrong-path rule: any input arriving in a cycle where ex_wrong=1 is dropped: no update, no count.
- Mispredict, registered, visible at t+1:
  - wrong = (pred_taken != taken) | (taken & pred_target != target).
  - ex_vld = acc delayed one cycle; ex_wrong = ex_vld & wrong.
  - redirect_pc = taken ? target : pc+4, computed mod 2^ADDR_WIDTH.
- Stage B (t+1), conditional branches only:
  - e = pc[2] ? past_rdata2 : past_rdata1, with matching rvld.
  - If rvld=0, e is replaced by h=00 and all counters 01 before updating.
  - Counter c[h]: saturating +1 if taken (max 11), saturating -1 if not taken (min 00). Other counters unchanged.
  - New h = {h[0], taken}.
  - Drive past_we=1 with waddr/wslot from the stored pc.
- Info write at t+1 whenever taken: info_we=1, info_wdata = {target[ADDR_WIDTH-1:2], ~cond, cond & rvld_after_update}. Bit0 is always 1 for conditional branches because the entry is valid after write.
- Not-taken unconditional branches cannot occur; no info write for not-taken branches.
- Bypass: the tables return old data on same-cycle read/write of one address. If stage B writes (addr, slot) at cycle t+1 and the update accepted at t+1 targets the same (addr, slot), stage B at t+2 must use the forwarded past_wdata, treated as valid, not the table data. This is required for back-to-back updates to one branch.
- Throughput is 1 update/cycle with no stalls; ex_vld is a single-cycle pulse per accepted update.
- Counters:
  - br_cnt +1 per ex_vld.
  - miss_cnt +1 per ex_wrong.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Reset mid-stream: assert rstn=0 while ex_vld=1 -> all outputs 0 immediately (asynchronous); no past_we/info_we after release.
- Cold conditional: pc=0x1C000010, taken=1, pred_taken=0, rvld=0 -> t+1: ex_wrong=1, redirect_pc=target; past_wdata=10'b01_01_01_01_10 (h=01, c0=10); info_wdata[1:0]=01.
- Saturation: same branch taken 4x with c[h] at 11 -> counter stays 11; h sequence follows {h[0],1}; no ex_wrong when pred matches.
- Back-to-back same slot: two updates in consecutive cycles to pc=0x1C000024 -> second uses forwarded data; final counter reflects both increments.
- Wrong-path drop: ex_wrong=1 at cycle t+1 coincides with ex_in_vld=1 -> no ex_vld at t+2, br_cnt unchanged; unconditional jump pred_target mismatch -> ex_wrong=1, no past_we, info_wdata[1:0]=10.
- Counter saturation: preload br_cnt to 0xFFFFFFFF -> stays 0xFFFFFFFF after further branches.
